// File: rtl/led_event_blinker.sv
// Turns single-cycle event pulses into visible LED blink bursts: N blinks, then a dark gap.
// Optional one-deep pending request buffer enabled by defining PENDING_BUF_EN.
module led_event_blinker #(
    parameter int ON_TIME  = 10_000_000,
    parameter int OFF_TIME = 10_000_000,
    parameter int GAP_TIME = 30_000_000,
    parameter int CNT_W    = 25
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       evt_pulse,
    input  logic [2:0] evt_count,
    output logic       led,
    output logic       busy,
    output logic       drop_pulse
);

    typedef enum logic [1:0] {IDLE, ON, OFF, GAP} state_t;

    localparam logic [CNT_W-1:0] ON_TERM  = CNT_W'(ON_TIME - 1);
    localparam logic [CNT_W-1:0] OFF_TERM = CNT_W'(OFF_TIME - 1);
    localparam logic [CNT_W-1:0] GAP_TERM = CNT_W'(GAP_TIME - 1);

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n, term;
    logic [2:0]       rem, rem_n;
    logic             drop_n, busy_n;
    logic             phase_done;
    logic             evt_used;

`ifdef PENDING_BUF_EN
    logic       buf_vld, buf_vld_n;
    logic [2:0] buf_cnt, buf_cnt_n;
    logic       buf_take;
`endif

    always_comb begin
        case (state)
            ON:      term = ON_TERM;
            OFF:     term = OFF_TERM;
            GAP:     term = GAP_TERM;
            default: term = '0;
        endcase
    end

    assign phase_done = (cnt == term);

    always_comb begin
        state_n  = state;
        rem_n    = rem;
        drop_n   = 1'b0;
        evt_used = 1'b0;
        cnt_n    = phase_done ? cnt : cnt + 1'b1;
`ifdef PENDING_BUF_EN
        buf_vld_n = buf_vld;
        buf_cnt_n = buf_cnt;
        buf_take  = 1'b0;
`endif

        case (state)
            IDLE: begin
`ifdef PENDING_BUF_EN
                // A request parked during the final gap cycle starts from here
                if (buf_vld) begin
                    buf_take = 1'b1;
                    state_n  = ON;
                    rem_n    = (buf_cnt == 3'd0) ? 3'd1 : buf_cnt;
                end else
`endif
                if (evt_pulse) begin
                    evt_used = 1'b1;
                    state_n  = ON;
                    rem_n    = (evt_count == 3'd0) ? 3'd1 : evt_count;
                end
            end
            ON: begin
                if (phase_done) begin
                    if (rem > 3'd1) begin
                        state_n = OFF;
                        rem_n   = rem - 3'd1;
                    end else begin
                        state_n = GAP;
                        rem_n   = 3'd0;
                    end
                end
            end
            OFF: begin
                if (phase_done) state_n = ON;
            end
            GAP: begin
                if (phase_done) begin
`ifdef PENDING_BUF_EN
                    if (buf_vld) begin
                        buf_take = 1'b1;
                        state_n  = ON;
                        rem_n    = (buf_cnt == 3'd0) ? 3'd1 : buf_cnt;
                    end else
`endif
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase

`ifdef PENDING_BUF_EN
        if (buf_take) buf_vld_n = 1'b0;
        // Oldest request wins; a slot freed this cycle can take the new one
        if (evt_pulse && !evt_used) begin
            if (!buf_vld || buf_take) begin
                buf_vld_n = 1'b1;
                buf_cnt_n = evt_count;
            end else begin
                drop_n = 1'b1;
            end
        end
        busy_n = (state_n != IDLE) || buf_vld_n;
`else
        if (evt_pulse && !evt_used) drop_n = 1'b1;
        busy_n = (state_n != IDLE);
`endif

        if (state_n != state) cnt_n = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            rem        <= '0;
            led        <= 1'b0;
            busy       <= 1'b0;
            drop_pulse <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            rem        <= rem_n;
            led        <= (state_n == ON);
            busy       <= busy_n;
            drop_pulse <= drop_n;
        end
    end

`ifdef PENDING_BUF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_vld <= 1'b0;
            buf_cnt <= '0;
        end else begin
            buf_vld <= buf_vld_n;
            buf_cnt <= buf_cnt_n;
        end
    end
`endif

endmodule

// File: tb/tb_led_event_blinker.sv
// Directed bench for led_event_blinker with ON=4, OFF=3, GAP=5; expectations follow
// whichever PENDING_BUF_EN setting the design is built with.
module tb_led_event_blinker;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       evt_pulse = 1'b0;
    logic [2:0] evt_count = 3'd0;
    logic       led, busy, drop_pulse;

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;

    led_event_blinker #(.ON_TIME(4), .OFF_TIME(3), .GAP_TIME(5), .CNT_W(25)) dut (
        .clk(clk), .rst_n(rst_n), .evt_pulse(evt_pulse), .evt_count(evt_count),
        .led(led), .busy(busy), .drop_pulse(drop_pulse)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%0d exp=%0d", tag, cyc, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        evt_pulse = 1'b0;
        evt_count = 3'd0;
        tick();
        tick();
        rst_n = 1'b1;
        cyc   = 0;
    endtask

    function automatic bit in_rng(input int c, input int lo, input int hi);
        return (c >= lo) && (c <= hi);
    endfunction

    // Cycle c is the interval after clock edge c; pulses driven in cycle c are sampled at edge c+1.
    task automatic run_case(input int id);
        int  last;
        bit  e_led, e_busy, e_drop, p;
        logic [2:0] pc;
        case (id)
            1: last = 30;
            3: last = 46;
            default: last = 32;
        endcase
        for (int c = 1; c <= last; c++) begin
            tick();
            e_led = 0; e_busy = 0; e_drop = 0; p = 0; pc = 3'd0;
            case (id)
                1: begin
                    e_led  = in_rng(c, 11, 14) || in_rng(c, 18, 21);
                    e_busy = in_rng(c, 11, 26);
                    if (c == 10) begin p = 1; pc = 3'd2; end
                end
                2: begin
                    e_led  = in_rng(c, 11, 14);
                    e_busy = in_rng(c, 11, 19);
                    if (c == 10) begin p = 1; pc = 3'd0; end
                end
                3: begin
`ifdef PENDING_BUF_EN
                    e_led  = in_rng(c, 11, 14) || in_rng(c, 20, 23) ||
                             in_rng(c, 27, 30) || in_rng(c, 34, 37);
                    e_busy = in_rng(c, 11, 42);
                    e_drop = (c == 14);
`else
                    e_led  = in_rng(c, 11, 14);
                    e_busy = in_rng(c, 11, 19);
                    e_drop = (c == 13) || (c == 14);
`endif
                    if (c == 10) begin p = 1; pc = 3'd1; end
                    if (c == 12) begin p = 1; pc = 3'd3; end
                    if (c == 13) begin p = 1; pc = 3'd2; end
                end
                4: begin
`ifdef PENDING_BUF_EN
                    e_led  = in_rng(c, 11, 14) || in_rng(c, 21, 24);
                    e_busy = in_rng(c, 11, 29);
`else
                    e_led  = in_rng(c, 11, 14);
                    e_busy = in_rng(c, 11, 19);
                    e_drop = (c == 20);
`endif
                    if (c == 10) begin p = 1; pc = 3'd1; end
                    if (c == 19) begin p = 1; pc = 3'd1; end
                end
                default: ;
            endcase
            chk($sformatf("c%0d_led", id), int'(led), int'(e_led));
            chk($sformatf("c%0d_busy", id), int'(busy), int'(e_busy));
            chk($sformatf("c%0d_drop", id), int'(drop_pulse), int'(e_drop));
            evt_pulse = p;
            evt_count = pc;
        end
        evt_pulse = 1'b0;
    endtask

    initial begin
        do_reset();
        chk("rst_led", int'(led), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_drop", int'(drop_pulse), 0);

        run_case(1);
        do_reset();
        run_case(2);
        do_reset();
        run_case(3);
        do_reset();
        run_case(4);

        // Async reset in the middle of an ON phase
        do_reset();
        for (int c = 1; c <= 12; c++) begin
            tick();
            evt_pulse = (c == 10);
            evt_count = 3'd3;
        end
        evt_pulse = 1'b0;
        chk("c5_led_pre", int'(led), 1);
        chk("c5_busy_pre", int'(busy), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("c5_led_rst", int'(led), 0);
        chk("c5_busy_rst", int'(busy), 0);
        chk("c5_drop_rst", int'(drop_pulse), 0);
        #1 rst_n = 1'b1;
        cyc = 0;
        run_case(2);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout cyc=%0d got=running exp=finished", cyc);
        $fatal(1);
    end

endmodule
